dmem_wait_ctrl: RTL
===================

Name: dmem_wait_ctrl

Overview:
Data-memory controller directly downstream of the CPU memory-control stage. It consumes that stage's byte-lane write enables, read enable, address and lane-replicated write data, and models a word-organised data RAM with a programmable access latency. It returns read data and a Busy signal that drives the stage's MemReadyFromMem input (1 = access in progress). Busy timing must allow the stage's RW_Mask handshake to close.

Parameters:
ADDR_BITS, 10, word-address width; the RAM holds 2^ADDR_BITS 32-bit words.
LATENCY, 2, wait cycles between request acceptance and completion; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
Address  input  32  byte address from the memory-control stage; bits [1:0] are ignored.
DataIn  input  32  write data, already lane-replicated upstream.
WriteEnable  input  4  per-byte write strobes; bit3 = DataIn[31:24].
ReadEnable  input  1  read request.
DataOut  output  32  registered read data (the stage's DataFromMem).
Busy  output  1  1 = request seen or access pending (the stage's MemReadyFromMem).
AddrErr  output  1  one-cycle pulse when a completed access had an out-of-range address.

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE, counter=0, DataOut=0, Busy=0, AddrErr=0, latched request cleared. RAM contents are not reset.
- Request: req = ReadEnable | (WriteEnable != 0).
- States: IDLE and WAIT.
- IDLE:
  - Busy = req, combinational. This is required so the upstream stage sets its RW_Mask in the request cycle.
  - On req, latch Address[ADDR_BITS+1:2], DataIn, WriteEnable and the read flag; load counter = LATENCY-1; go to WAIT.
- WAIT:
  - Busy=1. Input changes are ignored; the latched copy is used.
  - Counter decrements each cycle.
  - At the edge where counter==0, perform the access and return to IDLE.
- Latency: Busy is high for exactly LATENCY+1 cycles (request cycle plus LATENCY WAIT cycles). Busy=0 in the first IDLE cycle after completion, and DataOut is valid in that cycle.
- Write: only lanes with a latched WriteEnable bit are updated. Other bytes of the word keep their value. DataOut is unchanged.
- Read: DataOut <= RAM[word]. DataOut holds until the next completed read or reset.
- Simultaneous read and write (ReadEnable=1 and WriteEnable!=0): performed as a write only. DataOut is unchanged.
- Out of range (Address[31:ADDR_BITS+2] != 0): writes are dropped, reads load DataOut=0, and AddrErr=1 for one cycle, aligned with Busy falling.
- Back-to-back: a req present in the first IDLE cycle after completion is accepted as a new request. Busy then stays high with no low cycle. The upstream RW_Mask normally masks requests in that cycle.
- Reset mid-WAIT: the pending access is abandoned. No RAM write occurs and DataOut=0.

Test Plan:
- LATENCY=2, write 0xDEADBEEF with WE=4'b1111 to 0x40, then read 0x40 -> Busy high for 3 cycles on each access; DataOut=0xDEADBEEF in the cycle Busy falls after the read.
- Word 0x40 = 0xDEADBEEF, write 0x12121212 with WE=4'b0100 -> subsequent read returns 0xDE12BEEF.
- Drive Address, DataIn and WE to new values during WAIT -> the access uses the values latched at request; RAM is unchanged at the new address.
- Write to 0x00010000 with ADDR_BITS=10, then read it -> RAM is unchanged; AddrErr pulses once per access; read DataOut=0x00000000.
- rst=0 during the WAIT of a write of 0xCAFEF00D to 0x80 -> Busy=0 and DataOut=0 immediately; a later read of 0x80 returns the old contents.
- LATENCY=1 with ReadEnable and WE=4'b0011 asserted together -> treated as a write; Busy high for 2 cycles; DataOut unchanged.

Source files
------------

// File: rtl/dmem_wait_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_wait_ctrl_if
// Bus between the CPU memory-control stage (master) and the data-memory wait
// controller (slave).
//
// Handshake: the stage presents a request by raising ReadEnable and/or any
// WriteEnable bit, with Address/DataIn valid in the same cycle. The controller
// answers with Busy=1 in that same cycle and keeps Busy high until the access
// has finished. The first cycle with Busy=0 after a request is the completion
// cycle: DataOut (reads) and AddrErr are valid there. A request still present
// in that cycle is taken as a new request, so Busy stays high without a gap.
//
// Signals:
//   Address     master->slave  32  byte address, bits [1:0] ignored
//   DataIn      master->slave  32  lane-replicated write data
//   WriteEnable master->slave   4  byte strobes, bit3 = DataIn[31:24]
//   ReadEnable  master->slave   1  read request
//   DataOut     slave->master  32  registered read data
//   Busy        slave->master   1  request seen or access pending
//   AddrErr     slave->master   1  one-cycle out-of-range completion pulse
// -----------------------------------------------------------------------------
interface dmem_wait_ctrl_if;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [3:0]  WriteEnable;
  logic        ReadEnable;
  logic [31:0] DataOut;
  logic        Busy;
  logic        AddrErr;

  modport master (
    output Address, DataIn, WriteEnable, ReadEnable,
    input  DataOut, Busy, AddrErr
  );

  modport slave (
    input  Address, DataIn, WriteEnable, ReadEnable,
    output DataOut, Busy, AddrErr
  );
endinterface

// File: rtl/dmem_wait_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_wait_ctrl
// Word-organised data RAM with a programmable access latency, placed directly
// after the CPU memory-control stage. A request is latched in the cycle it is
// seen, the controller waits LATENCY cycles, then performs the access on the
// latched copy. Busy drives the stage's MemReadyFromMem input.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          dmem_wait_ctrl_if.slave (request in, DataOut/Busy/AddrErr out)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = WAIT)
//
// Parameters:
//   ADDR_BITS    word-address width; RAM holds 2^ADDR_BITS 32-bit words
//   LATENCY      wait cycles between acceptance and completion, 1..15
// -----------------------------------------------------------------------------
module dmem_wait_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_wait_ctrl_if.slave  bus,
  output logic             o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_oor;
  logic                 r_rd;
  logic [31:0]          r_wdata;
  logic [3:0]           r_we;
  logic [31:0]          r_dout;
  logic                 r_addr_err;
  logic [31:0]          r_mem [0:(1<<ADDR_BITS)-1];

  logic w_req;
  logic w_oor;
  logic w_accept;
  logic w_done;
  logic w_do_write;
  logic w_do_read;
  logic w_unused_addr;

  // Byte offset bits carry no information for a word RAM.
  assign w_unused_addr = ^bus.Address[1:0];

  assign w_req    = bus.ReadEnable | (|bus.WriteEnable);
  assign w_oor    = |bus.Address[31:ADDR_BITS+2];
  assign w_accept = (r_state == S_IDLE) && w_req;
  assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // A request carrying both read and write strobes is treated as a write.
  assign w_do_write = w_done && (|r_we) && !r_oor;
  assign w_do_read  = w_done && (r_we == 4'd0) && r_rd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req)  w_next = S_WAIT;
      S_WAIT: if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Busy is combinational on the request in IDLE so the upstream stage sees
  // it in the request cycle itself and can close its RW_Mask handshake.
  always_comb begin
    bus.Busy    = 1'b0;
    o_dbg_state = r_state;
    case (r_state)
      S_IDLE: bus.Busy = w_req;
      S_WAIT: bus.Busy = 1'b1;
      default: bus.Busy = 1'b0;
    endcase
  end

  // ---------------- Request latch, counter, read data, error pulse ----------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_oor      <= 1'b0;
      r_rd       <= 1'b0;
      r_wdata    <= 32'd0;
      r_we       <= 4'd0;
      r_dout     <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_addr  <= bus.Address[ADDR_BITS+1:2];
        r_oor   <= w_oor;
        r_rd    <= bus.ReadEnable;
        r_wdata <= bus.DataIn;
        r_we    <= bus.WriteEnable;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Pulse lands in the first IDLE cycle, together with Busy falling.
      r_addr_err <= w_done && r_oor;

      if (w_do_read) begin
        r_dout <= r_oor ? 32'd0 : r_mem[r_addr];
      end
    end
  end

  // ---------------- RAM (not reset) ----------------
  // Writes are gated by the FSM, so a reset during WAIT cancels the write.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_we[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.DataOut = r_dout;
  assign bus.AddrErr = r_addr_err;

endmodule
